// File: rtl/tx_cfg_commit_sched.sv
// tx_cfg_commit_sched
//
// Transmit-side configuration commit scheduler for the clk_xgmii_tx domain.
// Already-synchronized configuration bits are filtered for stability. An
// accepted value is applied to the TX datapath only at a frame boundary.
// While an update waits for that boundary, new start-of-frame grants are
// withheld, so a frame never sees its configuration change while it is in
// flight.
//
// Ports:
//   clk_xgmii_tx    in   XGMII TX clock; all logic uses its rising edge
//   reset_xgmii_tx  in   asynchronous, active-high reset
//   cfg_in          in   synchronized configuration [DWIDTH-1:0]
//   frame_busy      in   TX datapath is mid-frame
//   sof_req         in   TX datapath requests to start a new frame
//   sof_gnt         out  permission to start the frame (combinational)
//   cfg_out         out  committed configuration (registered)
//   cfg_update      out  one-cycle pulse when cfg_out changes (registered)
//   cfg_pending     out  a change is being filtered or awaits commit (comb.)
//   update_cnt      out  saturating count of commits (registered)
//   o_dbg_state     out  current FSM state, for debug and checkers
//
// Parameters:
//   DWIDTH         number of configuration bits
//   STABLE_CYCLES  consecutive edges a new value must hold (minimum 2)
//   CNT_WIDTH      width of update_cnt
//   RESET_CFG      value of cfg_out while in reset
module tx_cfg_commit_sched #(
    parameter int                DWIDTH        = 4,
    parameter int                STABLE_CYCLES = 3,
    parameter int                CNT_WIDTH     = 8,
    parameter logic [DWIDTH-1:0] RESET_CFG     = '0
) (
    input  logic                 clk_xgmii_tx,
    input  logic                 reset_xgmii_tx,
    input  logic [DWIDTH-1:0]    cfg_in,
    input  logic                 frame_busy,
    input  logic                 sof_req,
    output logic                 sof_gnt,
    output logic [DWIDTH-1:0]    cfg_out,
    output logic                 cfg_update,
    output logic                 cfg_pending,
    output logic [CNT_WIDTH-1:0] update_cnt,
    output logic [1:0]           o_dbg_state
);

    localparam int SW = $clog2(STABLE_CYCLES + 1);
    // stab_cnt value on which the next matching sample makes the value stable.
    localparam logic [SW-1:0] STAB_LAST = SW'(STABLE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_FILTER    = 2'd1,
        ST_WAIT_IDLE = 2'd2,
        ST_COMMIT    = 2'd3
    } state_t;

    state_t                r_state;
    logic [DWIDTH-1:0]     r_shadow;
    logic [SW-1:0]         r_stab_cnt;
    logic [DWIDTH-1:0]     r_cfg_out;
    logic                  r_cfg_update;
    logic [CNT_WIDTH-1:0]  r_update_cnt;

    logic                  w_in_eq_out;
    logic                  w_in_eq_shadow;

    assign w_in_eq_out    = (cfg_in == r_cfg_out);
    assign w_in_eq_shadow = (cfg_in == r_shadow);

    always_ff @(posedge clk_xgmii_tx or posedge reset_xgmii_tx) begin
        if (reset_xgmii_tx) begin
            r_state      <= ST_IDLE;
            r_shadow     <= RESET_CFG;
            r_stab_cnt   <= '0;
            r_cfg_out    <= RESET_CFG;
            r_cfg_update <= 1'b0;
            r_update_cnt <= '0;
        end else begin
            // The update strobe is only ever high for the single commit edge.
            r_cfg_update <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (!w_in_eq_out) begin
                        r_shadow   <= cfg_in;
                        r_stab_cnt <= SW'(1);
                        r_state    <= ST_FILTER;
                    end
                end
                ST_FILTER: begin
                    if (w_in_eq_out) begin
                        // Input reverted to the committed value: nothing to do.
                        r_state <= ST_IDLE;
                    end else if (!w_in_eq_shadow) begin
                        r_shadow   <= cfg_in;
                        r_stab_cnt <= SW'(1);
                    end else if (r_stab_cnt == STAB_LAST) begin
                        r_state <= ST_WAIT_IDLE;
                    end else begin
                        r_stab_cnt <= r_stab_cnt + 1'b1;
                    end
                end
                ST_WAIT_IDLE: begin
                    if (w_in_eq_out) begin
                        r_state <= ST_IDLE;
                    end else if (!w_in_eq_shadow) begin
                        // A new value must earn stability from scratch.
                        r_shadow   <= cfg_in;
                        r_stab_cnt <= SW'(1);
                        r_state    <= ST_FILTER;
                    end else if (!frame_busy) begin
                        r_state <= ST_COMMIT;
                    end
                end
                ST_COMMIT: begin
                    // cfg_in is deliberately not looked at on this edge.
                    r_cfg_out    <= r_shadow;
                    r_cfg_update <= 1'b1;
                    if (r_update_cnt != {CNT_WIDTH{1'b1}}) begin
                        r_update_cnt <= r_update_cnt + 1'b1;
                    end
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Grants are blocked once a stable value is waiting for the frame
    // boundary. This keeps a new frame from starting ahead of the commit.
    assign sof_gnt     = sof_req & ((r_state == ST_IDLE) | (r_state == ST_FILTER));
    assign cfg_pending = (r_state != ST_IDLE);
    assign cfg_out     = r_cfg_out;
    assign cfg_update  = r_cfg_update;
    assign update_cnt  = r_update_cnt;
    assign o_dbg_state = r_state;

endmodule
